// File: rtl/kbd_rx_ctrl_if.sv
// MIO-side register bus of the keyboard receiver: KBDR/KBSR access and interrupt request.
interface kbd_rx_ctrl_if;
    logic        kbdr_rd;
    logic        kbsr_wr;
    logic [15:0] d_in;
    logic [15:0] kbdr;
    logic [15:0] kbsr;
    logic        kbd_irq;

    modport master (output kbdr_rd, kbsr_wr, d_in, input kbdr, kbsr, kbd_irq);
    modport slave  (input kbdr_rd, kbsr_wr, d_in, output kbdr, kbsr, kbd_irq);
endinterface

// File: rtl/kbd_rx_ctrl.sv
// Keyboard 8N1 receiver feeding a small FIFO, exposed as KBDR/KBSR with a ready interrupt.
//   state | meaning
//   IDLE  | line idle, waiting for a low level on rxs
//   START | timing to mid start bit, rejecting glitches
//   DATA  | sampling 8 data bits LSB first, one per bit period
//   STOP  | timing to mid stop bit, then push byte or flag framing error
module kbd_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    kbd_rx_ctrl_if.slave bus
);
    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [TW-1:0]    T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]    T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             rx_meta, rxs;
    logic [1:0]       state;
    logic [TW-1:0]    tmr;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             tc, stop_smp, push, frame_bad;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             not_empty, full, pop, push_ok, ovr_set;
    logic             ie, overrun, frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign tc        = (tmr == '0);
    assign stop_smp  = (state == S_STOP) && tc;
    assign push      = stop_smp && rxs;
    assign frame_bad = stop_smp && !rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        tmr   <= T_HALF;
                    end
                end
                S_START: begin
                    if (tc) begin
                        if (!rxs) begin
                            state   <= S_DATA;
                            tmr     <= T_FULL;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_DATA: begin
                    if (tc) begin
                        shreg   <= {rxs, shreg[7:1]};
                        tmr     <= T_FULL;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_STOP;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_STOP: begin
                    if (tc) state <= S_IDLE;
                    else    tmr   <= tmr - TW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign not_empty = (count != '0);
    assign full      = (count == FULL);
    assign pop       = bus.kbdr_rd && not_empty;
    assign push_ok   = push && (!full || pop);
    assign ovr_set   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Flag set beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie        <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (bus.kbsr_wr) ie <= bus.d_in[14];
            overrun   <= ovr_set   | (overrun   & ~(bus.kbsr_wr & bus.d_in[1]));
            frame_err <= frame_bad | (frame_err & ~(bus.kbsr_wr & bus.d_in[0]));
        end
    end

    assign bus.kbdr    = not_empty ? {8'h00, mem[rd_ptr]} : 16'h0000;
    assign bus.kbsr    = {not_empty, ie, 12'b0, overrun, frame_err};
    assign bus.kbd_irq = not_empty & ie;
endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// Directed bench for kbd_rx_ctrl: serial frames in, queue-based reference for FIFO and status.
module tb_kbd_rx_ctrl;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] q[$];
    logic       m_ie, m_ovr, m_fe;

    kbd_rx_ctrl_if bus ();

    kbd_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] exp_kbsr();
        return {(q.size() != 0), m_ie, 12'b0, m_ovr, m_fe};
    endfunction

    function automatic logic [15:0] exp_kbdr();
        return (q.size() != 0) ? {8'h00, q[0]} : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] irq_exp;
        irq_exp = {15'b0, (q.size() != 0) && m_ie};
        check({tag, ".kbdr"}, bus.kbdr, exp_kbdr());
        check({tag, ".kbsr"}, bus.kbsr, exp_kbsr());
        check({tag, ".irq"}, {15'b0, bus.kbd_irq}, irq_exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_ie  = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] w);
        m_ie = w[14];
        if (w[1]) m_ovr = 1'b0;
        if (w[0]) m_fe  = 1'b0;
    endtask

    // Called #1 after a rising edge; the stop sample lands CPB/2+3 edges into the stop bit.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic stop_bit,
                              input logic do_rd, input logic do_wr, input logic [15:0] wdata);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (CPB / 2 + 2) @(posedge clk);
        #1;
        check({tag, ".pre_push"}, bus.kbsr, exp_kbsr());
        bus.kbdr_rd = do_rd;
        bus.kbsr_wr = do_wr;
        bus.d_in    = wdata;
        @(posedge clk);
        #1;
        bus.kbdr_rd = 1'b0;
        bus.kbsr_wr = 1'b0;
        bus.d_in    = 16'h0000;
        if (do_rd && q.size() != 0) void'(q.pop_front());
        if (do_wr) model_write(wdata);
        if (stop_bit) begin
            if (q.size() < DEPTH) q.push_back(d);
            else                  m_ovr = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
        check_all(tag);
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic read_kbdr(input string tag);
        check({tag, ".head"}, bus.kbdr, exp_kbdr());
        bus.kbdr_rd = 1'b1;
        @(posedge clk);
        #1;
        bus.kbdr_rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_all(tag);
    endtask

    task automatic write_kbsr(input string tag, input logic [15:0] w);
        bus.kbsr_wr = 1'b1;
        bus.d_in    = w;
        @(posedge clk);
        #1;
        bus.kbsr_wr = 1'b0;
        bus.d_in    = 16'h0000;
        model_write(w);
        check_all(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        rx          = 1'b1;
        bus.kbdr_rd = 1'b0;
        bus.kbsr_wr = 1'b0;
        bus.d_in    = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("reset");

        // Reset in the middle of a frame, after a byte is already queued
        send_frame("pre_rst", 8'hA5, 1'b1, 1'b0, 1'b0, 16'h0);
        rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_mid");
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_all("after_rst");

        send_frame("byte41", 8'h41, 1'b1, 1'b0, 1'b0, 16'h0);
        read_kbdr("rd41");
        read_kbdr("rd_empty");

        write_kbsr("ie_on", 16'h4000);
        send_frame("byte0d", 8'h0D, 1'b1, 1'b0, 1'b0, 16'h0);
        read_kbdr("rd0d");
        write_kbsr("ie_off", 16'h0000);

        for (int i = 1; i <= 5; i++) send_frame("ovf", 8'(i), 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) read_kbdr("ovf_rd");
        write_kbsr("ovr_clr", 16'h0002);

        send_frame("frame55", 8'h55, 1'b0, 1'b0, 1'b0, 16'h0);
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_all("glitch");
        send_frame("fe_set_wins", 8'h33, 1'b0, 1'b0, 1'b1, 16'h0001);
        write_kbsr("fe_clr", 16'h0001);

        send_frame("one", 8'h10, 1'b1, 1'b0, 1'b0, 16'h0);
        send_frame("push_pop", 8'h7A, 1'b1, 1'b1, 1'b0, 16'h0);
        read_kbdr("rd7a");
        send_frame("push_pop_empty", 8'h22, 1'b1, 1'b1, 1'b0, 16'h0);
        read_kbdr("rd22");

        for (int i = 0; i < 4; i++) send_frame("fill", 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0, 16'h0);
        send_frame("push_pop_full", 8'hEE, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) read_kbdr("full_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
